class_switch_n: RTL and testbench
=================================

CLASS_SWITCH_N -- requirements
Module: class_switch_n

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 10, meaning word width in bits.
REQ-002 SHALL have parameter NUM_CLASS, default 4, meaning class count; power of 2, at least 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning words per class FIFO; power of 2.
REQ-004 SHALL have parameter CLASS_LSB, default 8, meaning LSB of the class field in[CLASS_LSB +: log2(NUM_CLASS)]; field SHALL fit inside DATA_SIZE.
REQ-005 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-2, meaning the almost-full occupancy threshold.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port valid, input, 1, meaning in carries a word this cycle.
REQ-009 SHALL have port in, input, DATA_SIZE, meaning the input word.
REQ-010 SHALL have port pop, input, NUM_CLASS, meaning per-class read request.
REQ-011 SHALL have port out, output, NUM_CLASS*DATA_SIZE, meaning per-class read data; class k occupies slice k.
REQ-012 SHALL have port out_valid, output, NUM_CLASS, meaning out slice k holds a newly popped word.
REQ-013 SHALL have port fifo_empty, output, NUM_CLASS, meaning class k FIFO occupancy is 0.
REQ-014 SHALL have port fifo_almostfull, output, NUM_CLASS, meaning class k occupancy is at least AFULL_THRESH.
REQ-015 SHALL have port fifo_full, output, NUM_CLASS, meaning class k occupancy equals FIFO_DEPTH.
REQ-016 SHALL have port error, output, 1, meaning sticky overflow/underflow flag.
REQ-017 SHALL have port drop_count, output, 16, meaning the number of words dropped on overflow.

Function
REQ-018 SHALL route each word with valid=1 to the FIFO selected by its class field; words with valid=0 SHALL be ignored.
REQ-019 SHALL implement one independent circular FIFO per class: log2(FIFO_DEPTH)-bit read and write pointers, each wrapping modulo FIFO_DEPTH, plus an occupancy counter of log2(FIFO_DEPTH)+1 bits.
REQ-020 SHALL decode fifo_empty, fifo_almostfull and fifo_full combinationally from the registered occupancy.
REQ-021 SHALL, on pop[k]=1 with FIFO k non-empty, register the head word into out slice k and assert out_valid[k] on the next cycle (1-cycle read latency).
REQ-022 SHALL hold out slice k at its last value when no pop occurs on k; out_valid[k] SHALL then be 0.
REQ-023 SHALL store a push and deliver it to out no earlier than 2 cycles after the push cycle (push at edge N, pop asserted at N+1, data at N+2).
REQ-024 SHALL, on a simultaneous push and pop to a non-empty, non-full FIFO, perform both and leave occupancy unchanged.
REQ-025 SHALL, on a push to a full FIFO with a same-cycle pop on that class, accept the push; occupancy stays FIFO_DEPTH.
REQ-026 SHALL, on a push to a full FIFO with no same-cycle pop, drop the word, set error, and increment drop_count; drop_count saturates at 0xFFFF.
REQ-027 SHALL ignore a pop on an empty FIFO (pointers and out unchanged, out_valid[k]=0) and set error; a same-cycle push into that empty FIFO SHALL NOT bypass to out.
REQ-028 SHALL process pops on multiple classes in the same cycle independently.
REQ-029 SHALL keep error at 1 from the cycle after it is set until reset.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, clear all pointers and occupancies, out to 0, out_valid to 0, error to 0, drop_count to 0; resulting flags: fifo_empty all 1, fifo_almostfull and fifo_full all 0.
REQ-031 SHALL give reset priority over valid and pop in the same cycle; a word pushed during reset SHALL be discarded.
REQ-032 SHALL, on reset asserted mid-operation, discard all stored words.
REQ-033 SHALL NOT need memory array contents cleared on reset.

Verification
REQ-034 SHALL cover routing: push 0x0AB, 0x1CD, 0x2EF, 0x3FF (classes 0..3) -> one word per FIFO; pop all classes together -> each out slice holds its word with out_valid=4'b1111 one cycle later.
REQ-035 SHALL cover fill and overflow: push 9 class-1 words 0x100..0x108 -> fifo_almostfull[1]=1 after 6, fifo_full[1]=1 after 8; 0x108 dropped, error=1, drop_count=1; pops return 0x100..0x107 in order.
REQ-036 SHALL cover underflow: pop[2]=1 with class 2 empty -> out_valid[2]=0, out slice 2 unchanged, error=1.
REQ-037 SHALL cover full with simultaneous push and pop: class 0 full, push 0x0AA with pop[0] -> push accepted, occupancy 8, no error, no drop; 0x0AA emerges after the 7 older words.
REQ-038 SHALL cover wrap-around: 20 interleaved push/pop pairs on class 3 -> pointers wrap twice, data in order, fifo_empty[3]=1 at end.
REQ-039 SHALL cover reset mid-stream: 5 words queued, reset for 1 cycle -> all fifo_empty=1, error=0, drop_count=0, out=0; a following pop gives out_valid=0.

Source files
------------

// File: rtl/class_switch_n.sv
`default_nettype none
// ============================================================================
// Module   : class_switch_n
// Purpose  : Routes valid words by class field into per-class circular FIFOs
//            with registered, per-class read ports and overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module class_switch_n #(
    parameter int DATA_SIZE    = 10,
    parameter int NUM_CLASS    = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLASS_LSB    = 8,
    parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid,
    input  logic [DATA_SIZE-1:0]           in,
    input  logic [NUM_CLASS-1:0]           pop,
    output logic [NUM_CLASS*DATA_SIZE-1:0] out,
    output logic [NUM_CLASS-1:0]           out_valid,
    output logic [NUM_CLASS-1:0]           fifo_empty,
    output logic [NUM_CLASS-1:0]           fifo_almostfull,
    output logic [NUM_CLASS-1:0]           fifo_full,
    output logic                           error,
    output logic [15:0]                    drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLS_W = $clog2(NUM_CLASS);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [CLS_W-1:0]     in_class;
    logic [NUM_CLASS-1:0] push_req;
    logic [NUM_CLASS-1:0] overflow;
    logic [NUM_CLASS-1:0] underflow;

    assign in_class = in[CLASS_LSB +: CLS_W];

    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_class
        logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]     wr_ptr;
        logic [PTR_W-1:0]     rd_ptr;
        logic [CNT_W-1:0]     count;
        logic [DATA_SIZE-1:0] out_word;
        logic                 out_flag;
        logic                 do_push;
        logic                 do_pop;

        assign push_req[k]  = valid && (in_class == CLS_W'(k));
        assign do_pop       = pop[k] && (count != '0);
        // A full FIFO still takes a push when the same cycle frees a slot.
        assign do_push      = push_req[k] && ((count != DEPTH_CNT) || do_pop);
        assign overflow[k]  = push_req[k] && (count == DEPTH_CNT) && !pop[k];
        assign underflow[k] = pop[k] && (count == '0);

        // Storage is left uncleared; pointers and occupancy define validity.
        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wr_ptr] <= in;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                out_word <= '0;
                out_flag <= 1'b0;
            end else begin
                out_flag <= do_pop;
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    out_word <= mem[rd_ptr];
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        assign out[k*DATA_SIZE +: DATA_SIZE] = out_word;
        assign out_valid[k]       = out_flag;
        assign fifo_empty[k]      = (count == '0);
        assign fifo_almostfull[k] = (count >= AFULL_CNT);
        assign fifo_full[k]       = (count == DEPTH_CNT);
    end

    // At most one word arrives per cycle, so at most one drop per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            error      <= 1'b0;
            drop_count <= '0;
        end else begin
            if ((|overflow) || (|underflow)) begin
                error <= 1'b1;
            end
            if ((|overflow) && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_class_switch_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_class_switch_n
// Purpose  : Scoreboard bench for class_switch_n with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_class_switch_n;

    localparam int DW    = 10;
    localparam int NC    = 4;
    localparam int DEPTH = 8;
    localparam int CLSB  = 8;
    localparam int AF    = DEPTH - 2;
    localparam int CW    = $clog2(NC);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic [DW-1:0]    in_w = '0;
    logic [NC-1:0]    pop_w = '0;
    logic [NC*DW-1:0] out;
    logic [NC-1:0]    out_valid;
    logic [NC-1:0]    fifo_empty;
    logic [NC-1:0]    fifo_almostfull;
    logic [NC-1:0]    fifo_full;
    logic             error;
    logic [15:0]      drop_count;

    class_switch_n #(
        .DATA_SIZE(DW), .NUM_CLASS(NC), .FIFO_DEPTH(DEPTH),
        .CLASS_LSB(CLSB), .AFULL_THRESH(AF)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .in(in_w), .pop(pop_w),
        .out(out), .out_valid(out_valid), .fifo_empty(fifo_empty),
        .fifo_almostfull(fifo_almostfull), .fifo_full(fifo_full),
        .error(error), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: contents of each class FIFO, plus words owed to the output port.
    logic [DW-1:0] mq  [NC][$];
    logic [DW-1:0] exq [NC][$];
    logic [DW-1:0] last_out [NC];
    bit            m_err = 1'b0;
    int            m_drops = 0;
    bit            done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Checks the registered state left by the previous edge, then drives the
    // next cycle's inputs and advances the model by that cycle.
    task automatic step(input bit rst, input bit v, input logic [DW-1:0] d, input logic [NC-1:0] p);
        logic [NC-1:0] e_empty, e_af, e_full;
        int c;
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            e_empty[k] = (mq[k].size() == 0);
            e_af[k]    = (mq[k].size() >= AF);
            e_full[k]  = (mq[k].size() == DEPTH);
        end
        check("fifo_empty", 32'(fifo_empty), 32'(e_empty));
        check("fifo_almostfull", 32'(fifo_almostfull), 32'(e_af));
        check("fifo_full", 32'(fifo_full), 32'(e_full));
        check("error", 32'(error), 32'(m_err));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        reset = rst;
        valid = v;
        in_w  = d;
        pop_w = p;
        if (rst) begin
            for (int k = 0; k < NC; k++) mq[k].delete();
            m_err   = 1'b0;
            m_drops = 0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (p[k]) begin
                    if (mq[k].size() > 0) exq[k].push_back(mq[k].pop_front());
                    else m_err = 1'b1;
                end
            end
            if (v) begin
                c = int'(d[CLSB +: CW]);
                if (mq[c].size() < DEPTH) begin
                    mq[c].push_back(d);
                end else begin
                    m_err = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    // Monitor: after every edge, out_valid must match owed words exactly.
    initial begin
        logic [DW-1:0] e;
        bit ev;
        for (int k = 0; k < NC; k++) last_out[k] = '0;
        while (!done) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NC; k++) begin
                if (reset) begin
                    check("out_valid_rst", 32'(out_valid[k]), 32'd0);
                    check("out_rst", 32'(out[k*DW +: DW]), 32'd0);
                    last_out[k] = '0;
                    exq[k].delete();
                end else begin
                    ev = (exq[k].size() != 0);
                    check("out_valid", 32'(out_valid[k]), 32'(ev));
                    if (ev) begin
                        e = exq[k].pop_front();
                        if (out_valid[k]) check("out_data", 32'(out[k*DW +: DW]), 32'(e));
                        last_out[k] = e;
                    end else begin
                        check("out_hold", 32'(out[k*DW +: DW]), 32'(last_out[k]));
                    end
                end
            end
        end
    end

    initial begin
        logic [NC-1:0] p;
        step(1, 0, '0, '0);
        step(1, 1, 10'h0AB, 4'b1111);
        step(0, 0, '0, '0);

        // Routing: one word per class, then pop all together.
        step(0, 1, 10'h0AB, '0);
        step(0, 1, 10'h1CD, '0);
        step(0, 1, 10'h2EF, '0);
        step(0, 1, 10'h3FF, '0);
        step(0, 0, '0, 4'b1111);
        step(0, 0, '0, '0);

        // Fill class 1 past full, then drain.
        for (int i = 0; i < 9; i++) step(0, 1, DW'(10'h100 + i), '0);
        for (int i = 0; i < 9; i++) step(0, 0, '0, 4'b0010);
        step(0, 0, '0, '0);

        // Underflow on class 2.
        step(0, 0, '0, 4'b0100);
        step(0, 0, '0, '0);

        // Full class 0 with simultaneous push and pop.
        step(1, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(10'h010 + i), '0);
        step(0, 1, 10'h0AA, 4'b0001);
        step(0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 4'b0001);
        step(0, 0, '0, '0);

        // Wrap-around on class 3.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, DW'(10'h300 + i), '0);
            step(0, 0, '0, 4'b1000);
        end
        step(0, 0, '0, '0);

        // Reset mid-stream, with a push and pop during the reset cycle.
        for (int i = 0; i < 5; i++) step(0, 1, DW'((i % NC) * 256 + 16 * i), '0);
        step(1, 1, 10'h155, 4'b1111);
        step(0, 0, '0, 4'b1111);
        step(0, 0, '0, '0);

        // Randomized traffic alternating fill-biased and drain-biased phases.
        for (int blk = 0; blk < 8; blk++) begin
            for (int i = 0; i < 100; i++) begin
                if (blk % 2 == 0) p = NC'($urandom & $urandom & $urandom);
                else              p = NC'($urandom | $urandom);
                step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                     DW'($urandom), p);
            end
        end
        step(0, 0, '0, '0);
        step(0, 0, '0, '0);

        done = 1'b1;
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
